// File: rtl/tt_accum_alu_if.sv
// Handshake and operand bundle for tt_accum_alu: operand/op input channel,
// result output channel and the synchronous accumulator clear.
interface tt_accum_alu_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 clear;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] result;
    logic                 ovf;
    logic                 ovf_sticky;

    modport master (
        output in_valid, op, a, b, clear, out_ready,
        input  in_ready, out_valid, result, ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, op, a, b, clear, out_ready,
        output in_ready, out_valid, result, ovf, ovf_sticky
    );
endinterface

// File: rtl/tt_accum_alu.sv
// Registered multi-mode arithmetic unit (ADD/SUB/ACC/MAC) with an internal
// accumulator, saturate-or-wrap overflow handling and a single-entry output register.
module tt_accum_alu #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    tt_accum_alu_if.slave bus
);

    generate
        if (ACC_WIDTH < 2 * WIDTH) begin : g_width_check
            $error("tt_accum_alu: ACC_WIDTH must be at least 2*WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_MAC = 2'b11
    } op_e;

    // Two guard bits hold any ACC/MAC sum before it is checked against MAX.
    localparam int EXT = ACC_WIDTH + 2;
    localparam logic [EXT-1:0]       MAX_EXT = {2'b00, {ACC_WIDTH{1'b1}}};
    localparam logic [ACC_WIDTH-1:0] MAX_ACC = {ACC_WIDTH{1'b1}};

    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] result_r;
    logic                 ovf_r;
    logic                 ovf_sticky_r;
    logic                 out_valid_r;

    logic                 accept_s;
    logic [EXT-1:0]       a_ext_s;
    logic [EXT-1:0]       b_ext_s;
    logic [EXT-1:0]       acc_eff_s;
    logic [EXT-1:0]       term_s;
    logic [EXT-1:0]       calc_s;
    logic [ACC_WIDTH-1:0] res_s;
    logic [ACC_WIDTH-1:0] acc_next_s;
    logic                 acc_load_s;
    logic                 ovf_s;

    assign bus.in_ready   = !out_valid_r || bus.out_ready;
    assign accept_s       = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = out_valid_r;
    assign bus.result     = result_r;
    assign bus.ovf        = ovf_r;
    assign bus.ovf_sticky = ovf_sticky_r;

    assign a_ext_s   = {{(EXT-WIDTH){1'b0}}, bus.a};
    assign b_ext_s   = {{(EXT-WIDTH){1'b0}}, bus.b};
    assign acc_eff_s = bus.clear ? {EXT{1'b0}} : {2'b00, acc_r};

    // Operation datapath: candidate result, overflow flag and accumulator update.
    always_comb begin
        term_s     = {EXT{1'b0}};
        calc_s     = {EXT{1'b0}};
        res_s      = {ACC_WIDTH{1'b0}};
        acc_next_s = acc_r;
        acc_load_s = 1'b0;
        ovf_s      = 1'b0;
        case (op_e'(bus.op))
            OP_ADD: begin
                calc_s = a_ext_s + b_ext_s;
                res_s  = calc_s[ACC_WIDTH-1:0];
            end
            OP_SUB: begin
                calc_s = a_ext_s - b_ext_s;
                if (bus.a < bus.b) begin
                    ovf_s = 1'b1;
                    res_s = SATURATE ? {ACC_WIDTH{1'b0}} : calc_s[ACC_WIDTH-1:0];
                end else begin
                    res_s = calc_s[ACC_WIDTH-1:0];
                end
            end
            OP_ACC, OP_MAC: begin
                if (op_e'(bus.op) == OP_MAC) begin
                    term_s = a_ext_s * b_ext_s;
                end else begin
                    term_s = a_ext_s + b_ext_s;
                end
                calc_s     = acc_eff_s + term_s;
                acc_load_s = 1'b1;
                if (calc_s > MAX_EXT) begin
                    ovf_s      = 1'b1;
                    acc_next_s = SATURATE ? MAX_ACC : calc_s[ACC_WIDTH-1:0];
                end else begin
                    acc_next_s = calc_s[ACC_WIDTH-1:0];
                end
                res_s = acc_next_s;
            end
            default: begin
                res_s = {ACC_WIDTH{1'b0}};
            end
        endcase
    end

    // Output register: load on accept, drop valid once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {ACC_WIDTH{1'b0}};
            ovf_r       <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            result_r    <= res_s;
            ovf_r       <= ovf_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Accumulator: accumulating ops already fold clear in through acc_eff_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else if (accept_s && acc_load_s) begin
            acc_r <= acc_next_s;
        end else if (bus.clear) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else begin
            acc_r <= acc_r;
        end
    end

    // Sticky overflow: a new overflow event wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_r <= 1'b0;
        end else if (accept_s && ovf_s) begin
            ovf_sticky_r <= 1'b1;
        end else if (bus.clear) begin
            ovf_sticky_r <= 1'b0;
        end else begin
            ovf_sticky_r <= ovf_sticky_r;
        end
    end

endmodule

// File: tb/tb_tt_accum_alu.sv
// Bench for tt_accum_alu: a saturating and a wrapping instance share one stimulus
// stream and are compared against a behavioural model of the unit.
module tb_tt_accum_alu;

    localparam int     W       = 8;
    localparam int     AW      = 16;
    localparam longint MOD     = 64'd65536;
    localparam longint MAXV    = MOD - 64'd1;
    localparam int     OP_ADD  = 0;
    localparam int     OP_SUB  = 1;
    localparam int     OP_ACC  = 2;
    localparam int     OP_MAC  = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tt_accum_alu_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus_s ();
    tt_accum_alu_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus_w ();

    tt_accum_alu #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(1'b1)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    tt_accum_alu #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(1'b0)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state; index 0 models the saturating unit, index 1 the wrapping one.
    longint acc_m [2];
    longint res_m [2];
    bit     ovf_m [2];
    bit     stk_m [2];
    bit     vld_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_m[k] = 0;
            res_m[k] = 0;
            ovf_m[k] = 1'b0;
            stk_m[k] = 1'b0;
        end
        vld_m = 1'b0;
    endtask

    task automatic ref_op(input bit sat, input int op_i, input longint a_i, input longint b_i,
                          input bit clr, inout longint acc, output longint res, output bit ov);
        longint s;
        ov  = 1'b0;
        res = 0;
        case (op_i)
            OP_ADD: res = a_i + b_i;
            OP_SUB: begin
                if (a_i >= b_i) begin
                    res = a_i - b_i;
                end else begin
                    ov  = 1'b1;
                    res = sat ? 0 : (a_i - b_i + MOD);
                end
            end
            default: begin
                s = (clr ? 0 : acc) + ((op_i == OP_ACC) ? (a_i + b_i) : (a_i * b_i));
                if (s > MAXV) begin
                    ov  = 1'b1;
                    acc = sat ? MAXV : (s % MOD);
                end else begin
                    acc = s;
                end
                res = acc;
            end
        endcase
        if (clr && op_i < OP_ACC) acc = 0;
    endtask

    task automatic drive(input bit iv, input int op_i, input int a_i, input int b_i,
                         input bit clr, input bit ordy);
        bus_s.in_valid = iv;   bus_w.in_valid = iv;
        bus_s.op = 2'(op_i);   bus_w.op = 2'(op_i);
        bus_s.a = W'(a_i);     bus_w.a = W'(a_i);
        bus_s.b = W'(b_i);     bus_w.b = W'(b_i);
        bus_s.clear = clr;     bus_w.clear = clr;
        bus_s.out_ready = ordy; bus_w.out_ready = ordy;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".sat.out_valid"}, 64'(bus_s.out_valid), 64'(vld_m));
        check({tag, ".wrap.out_valid"}, 64'(bus_w.out_valid), 64'(vld_m));
        if (vld_m) begin
            check({tag, ".sat.result"}, 64'(bus_s.result), 64'(res_m[0]));
            check({tag, ".wrap.result"}, 64'(bus_w.result), 64'(res_m[1]));
            check({tag, ".sat.ovf"}, 64'(bus_s.ovf), 64'(ovf_m[0]));
            check({tag, ".wrap.ovf"}, 64'(bus_w.ovf), 64'(ovf_m[1]));
        end
        check({tag, ".sat.sticky"}, 64'(bus_s.ovf_sticky), 64'(stk_m[0]));
        check({tag, ".wrap.sticky"}, 64'(bus_w.ovf_sticky), 64'(stk_m[1]));
    endtask

    // One clock: drive at negedge, check in_ready, clock, update model, check outputs.
    task automatic cycle(input string tag, input bit iv, input int op_i, input int a_i,
                         input int b_i, input bit clr, input bit ordy);
        bit     acc_ok;
        longint r;
        bit     o;
        @(negedge clk);
        drive(iv, op_i, a_i, b_i, clr, ordy);
        #1;
        acc_ok = iv && (!vld_m || ordy);
        check({tag, ".sat.in_ready"}, 64'(bus_s.in_ready), 64'(!vld_m || ordy));
        check({tag, ".wrap.in_ready"}, 64'(bus_w.in_ready), 64'(!vld_m || ordy));
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (acc_ok) begin
                ref_op(k == 0, op_i, longint'(a_i), longint'(b_i), clr, acc_m[k], r, o);
                res_m[k] = r;
                ovf_m[k] = o;
                stk_m[k] = o ? 1'b1 : (clr ? 1'b0 : stk_m[k]);
            end else if (clr) begin
                acc_m[k] = 0;
                stk_m[k] = 1'b0;
            end
        end
        if (acc_ok) vld_m = 1'b1;
        else if (ordy) vld_m = 1'b0;
        check_outs(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, OP_ADD, 0, 0, 1'b0, 1'b1);
        model_reset();

        // Reset state and release
        #12;
        check_outs("reset");
        check("reset.sat.result", 64'(bus_s.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release.in_ready", 64'(bus_s.in_ready), 64'd1);

        // Pending overflowed result, then asynchronous reset mid-stream
        cycle("pend", 1'b1, OP_SUB, 5, 7, 1'b0, 1'b0);
        check("pend.sat.sticky", 64'(bus_s.ovf_sticky), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.sat.out_valid", 64'(bus_s.out_valid), 64'd0);
        check("arst.wrap.result", 64'(bus_w.result), 64'd0);
        check("arst.sat.sticky", 64'(bus_s.ovf_sticky), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, OP_ADD, 0, 0, 1'b0, 1'b1);
        #1;
        check("arst.in_ready", 64'(bus_s.in_ready), 64'd1);

        // ADD 200+100
        cycle("add", 1'b1, OP_ADD, 200, 100, 1'b0, 1'b1);
        check("add.result", 64'(bus_s.result), 64'h012C);
        check("add.ovf", 64'(bus_s.ovf), 64'd0);

        // SUB 5-7 underflow
        cycle("sub", 1'b1, OP_SUB, 5, 7, 1'b0, 1'b1);
        check("sub.sat.result", 64'(bus_s.result), 64'd0);
        check("sub.wrap.result", 64'(bus_w.result), 64'hFFFE);
        check("sub.wrap.ovf", 64'(bus_w.ovf), 64'd1);
        check("sub.sat.sticky", 64'(bus_s.ovf_sticky), 64'd1);

        // MAC 255*255 twice from an empty accumulator
        cycle("clr1", 1'b0, OP_ADD, 0, 0, 1'b1, 1'b1);
        cycle("mac1", 1'b1, OP_MAC, 255, 255, 1'b0, 1'b1);
        check("mac1.result", 64'(bus_s.result), 64'd65025);
        check("mac1.ovf", 64'(bus_s.ovf), 64'd0);
        cycle("mac2", 1'b1, OP_MAC, 255, 255, 1'b0, 1'b1);
        check("mac2.sat.result", 64'(bus_s.result), 64'hFFFF);
        check("mac2.wrap.result", 64'(bus_w.result), 64'd64514);
        check("mac2.sat.ovf", 64'(bus_s.ovf), 64'd1);

        // Backpressure: 3 held, 9 stalled, then both flow with no bubble
        cycle("drain", 1'b0, OP_ADD, 0, 0, 1'b1, 1'b1);
        cycle("bp1", 1'b1, OP_ADD, 1, 2, 1'b0, 1'b0);
        check("bp1.result", 64'(bus_s.result), 64'd3);
        cycle("bp2", 1'b1, OP_ADD, 4, 5, 1'b0, 1'b0);
        check("bp2.held", 64'(bus_s.result), 64'd3);
        cycle("bp3", 1'b1, OP_ADD, 4, 5, 1'b0, 1'b0);
        check("bp3.held", 64'(bus_w.result), 64'd3);
        cycle("bp4", 1'b1, OP_ADD, 4, 5, 1'b0, 1'b1);
        check("bp4.result", 64'(bus_s.result), 64'd9);
        check("bp4.out_valid", 64'(bus_s.out_valid), 64'd1);
        cycle("bp5", 1'b0, OP_ADD, 0, 0, 1'b0, 1'b1);
        check("bp5.out_valid", 64'(bus_s.out_valid), 64'd0);

        // Accumulate, clear with accept, clear alone, clear with overflow
        cycle("acc1", 1'b1, OP_ACC, 3, 4, 1'b0, 1'b1);
        check("acc1.result", 64'(bus_s.result), 64'd7);
        cycle("acc2", 1'b1, OP_ACC, 1, 1, 1'b0, 1'b1);
        check("acc2.result", 64'(bus_s.result), 64'd9);
        cycle("setstk", 1'b1, OP_SUB, 0, 9, 1'b0, 1'b1);
        cycle("clracc", 1'b1, OP_ACC, 3, 4, 1'b1, 1'b1);
        check("clracc.result", 64'(bus_s.result), 64'd7);
        check("clracc.sticky", 64'(bus_s.ovf_sticky), 64'd0);
        cycle("clr2", 1'b0, OP_MAC, 9, 9, 1'b1, 1'b1);
        cycle("acc0", 1'b1, OP_ACC, 0, 0, 1'b0, 1'b1);
        check("acc0.result", 64'(bus_w.result), 64'd0);
        cycle("clrovf", 1'b1, OP_SUB, 0, 1, 1'b1, 1'b1);
        check("clrovf.sticky", 64'(bus_s.ovf_sticky), 64'd1);

        // Randomised traffic with backpressure and occasional clears
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  $urandom_range(3, 0) != 0,
                  int'($urandom_range(3, 0)),
                  int'($urandom_range(255, 0)),
                  int'($urandom_range(255, 0)),
                  $urandom_range(15, 0) == 0,
                  $urandom_range(1, 0) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
